// File: rtl/aes_key_sched.sv
// AES-128 key schedule: one shared expansion round reused once per cycle.
// All NROUNDS+1 round keys are kept in a register file behind a
// combinational indexed read port.

// Forward AES S-box, single byte, pure lookup.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_q
);
  // Byte 0 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_q = SBOX[(11'd2047 - {i_a, 3'b000}) -: 8];
endmodule

module aes_key_sched #(
  parameter int          NROUNDS   = 10,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         keys_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic [127:0] r_work;
  logic         r_keys_ready;
  logic [127:0] r_rk [0:NROUNDS];

  logic         w_load, w_step, w_last;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t;
  logic [31:0]  w_y0, w_y1, w_y2, w_y3;
  logic [127:0] w_nk;
  logic [7:0]   w_rcon_nxt;
  logic [127:0] w_rd_tab [0:15];

  // Expansion round datapath: RotWord -> SubWord -> Rcon -> XOR chain.
  assign {w_w0, w_w1, w_w2, w_w3} = r_work;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sb
      aes_sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_q(w_sub[8*g +: 8]));
    end
  endgenerate

  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_y0 = w_w0 ^ w_t;
  assign w_y1 = w_w1 ^ w_y0;
  assign w_y2 = w_w2 ^ w_y1;
  assign w_y3 = w_w3 ^ w_y2;
  assign w_nk = {w_y0, w_y1, w_y2, w_y3};

  // xtime in GF(2^8) gives the next round constant.
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  // Read port padded to 16 entries so out-of-range indices return zero.
  generate
    for (g = 0; g < 16; g++) begin : g_rd
      if (g <= NROUNDS) begin : g_hit
        assign w_rd_tab[g] = r_rk[g];
      end else begin : g_miss
        assign w_rd_tab[g] = '0;
      end
    end
  endgenerate

  assign rd_key     = w_rd_tab[rd_idx];
  assign busy       = (r_state == S_EXPAND);
  assign keys_ready = r_keys_ready;

  // Next-state and datapath enables; loads are only seen in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_load) begin
          w_load      = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_step = 1'b1;
        if (r_round == 4'(NROUNDS)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Key register file, working key, round counter and rcon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round      <= '0;
      r_rcon       <= RCON_INIT;
      r_work       <= '0;
      r_keys_ready <= 1'b0;
      for (int i = 0; i <= NROUNDS; i++) r_rk[i] <= '0;
    end else if (w_load) begin
      r_rk[0]      <= key_in;
      r_work       <= key_in;
      r_round      <= 4'd1;
      r_rcon       <= RCON_INIT;
      r_keys_ready <= 1'b0;
    end else if (w_step) begin
      r_rk[r_round] <= w_nk;
      r_work        <= w_nk;
      r_round       <= r_round + 4'd1;
      r_rcon        <= w_rcon_nxt;
      if (w_last) r_keys_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: FIPS-197 vectors plus random keys against a
// word-level key expansion model with an arithmetically derived S-box.
module tb_aes_key_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy, keys_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_sched dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy), .keys_ready(keys_ready), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic init_sbox();
    logic [7:0] inv, x;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (x != 0 && gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion over 44 words.
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_load = 1'b0; key_in = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++;
    if (keys_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", keys_ready); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++;
      if (rd_key !== 128'h0) begin n_err++; $display("FAIL reset_rk[%0d] got %h exp 0", i, rd_key); end
    end
  endtask

  task automatic test_fips();
    int n;
    compute_model(FIPS_KEY);
    load_key(FIPS_KEY);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    n_cmp++;
    if (n !== 10) begin n_err++; $display("FAIL fips_busy_cycles got %0d exp 10", n); end
    n_cmp++;
    if (keys_ready !== 1'b1) begin n_err++; $display("FAIL fips_ready got %b exp 1", keys_ready); end
    rd_idx = 4'd0;  #1; n_cmp++;
    if (rd_key !== FIPS_KEY) begin n_err++; $display("FAIL fips_rk0 got %h exp %h", rd_key, FIPS_KEY); end
    rd_idx = 4'd1;  #1; n_cmp++;
    if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_err++; $display("FAIL fips_rk1 got %h", rd_key); end
    rd_idx = 4'd7;  #1; n_cmp++;
    if (rd_key !== 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f) begin n_err++; $display("FAIL fips_rk7 got %h", rd_key); end
    rd_idx = 4'd10; #1; n_cmp++;
    if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_err++; $display("FAIL fips_rk10 got %h", rd_key); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1; n_cmp++;
      if (rd_key !== ((i <= 10) ? exp_rk[i] : 128'h0)) begin
        n_err++; $display("FAIL fips_model_rk[%0d] got %h exp %h", i, rd_key, (i <= 10) ? exp_rk[i] : 128'h0);
      end
    end
  endtask

  task automatic test_ignored_load();
    int n;
    compute_model(FIPS_KEY);
    load_key(FIPS_KEY);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 4) begin key_in = '0; key_load = 1'b1; end
      if (n == 5) key_load = 1'b0;
      @(negedge clk);
    end
    key_load = 1'b0;
    n_cmp++;
    if (n !== 10) begin n_err++; $display("FAIL ign_busy_cycles got %0d exp 10", n); end
    n_cmp++;
    if (keys_ready !== 1'b1) begin n_err++; $display("FAIL ign_ready got %b exp 1", keys_ready); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1; n_cmp++;
      if (rd_key !== exp_rk[i]) begin n_err++; $display("FAIL ign_rk[%0d] got %h exp %h", i, rd_key, exp_rk[i]); end
    end
  endtask

  task automatic test_reload();
    int n;
    logic [127:0] old10;
    old10 = exp_rk[10];
    compute_model(128'h0);
    load_key(128'h0);
    n_cmp++;
    if (keys_ready !== 1'b0) begin n_err++; $display("FAIL reload_ready_drop got %b exp 0", keys_ready); end
    rd_idx = 4'd0; #1; n_cmp++;
    if (rd_key !== 128'h0) begin n_err++; $display("FAIL reload_rk0 got %h exp 0", rd_key); end
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 10) begin
        rd_idx = 4'd10; #1; n_cmp++;
        if (rd_key !== old10) begin n_err++; $display("FAIL reload_rk10_off9 got %h exp %h", rd_key, old10); end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 10) begin n_err++; $display("FAIL reload_busy_cycles got %0d exp 10", n); end
    rd_idx = 4'd10; #1; n_cmp++;
    if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_err++; $display("FAIL reload_rk10 got %h", rd_key); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1; n_cmp++;
      if (rd_key !== exp_rk[i]) begin n_err++; $display("FAIL reload_rk[%0d] got %h exp %h", i, rd_key, exp_rk[i]); end
    end
  endtask

  task automatic test_reset_midop();
    int n;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 5) begin rst = 1'b1; #1; end
      else @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_cmp++;
    if (keys_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b exp 0", keys_ready); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1; n_cmp++;
      if (rd_key !== 128'h0) begin n_err++; $display("FAIL midrst_rk[%0d] got %h exp 0", i, rd_key); end
    end
    @(negedge clk);
    rst = 1'b0;
    k = {$urandom, $urandom, $urandom, $urandom};
    compute_model(k);
    load_key(k);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    n_cmp++;
    if (n !== 10) begin n_err++; $display("FAIL midrst_reload_cycles got %0d exp 10", n); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1; n_cmp++;
      if (rd_key !== exp_rk[i]) begin n_err++; $display("FAIL midrst_rk_after[%0d] got %h exp %h", i, rd_key, exp_rk[i]); end
    end
  endtask

  task automatic test_held_load();
    int n;
    logic [127:0] ka, kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key_in = ka; key_load = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    compute_model(ka);
    n_cmp++;
    if (n !== 10) begin n_err++; $display("FAIL held_busy_cycles got %0d exp 10", n); end
    n_cmp++;
    if (keys_ready !== 1'b1) begin n_err++; $display("FAIL held_ready_idle got %b exp 1", keys_ready); end
    rd_idx = 4'd10; #1; n_cmp++;
    if (rd_key !== exp_rk[10]) begin n_err++; $display("FAIL held_rk10_a got %h exp %h", rd_key, exp_rk[10]); end
    key_in = kb;
    @(negedge clk);
    key_load = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL held_restart_busy got %b exp 1", busy); end
    n_cmp++;
    if (keys_ready !== 1'b0) begin n_err++; $display("FAIL held_ready_drop got %b exp 0", keys_ready); end
    rd_idx = 4'd0; #1; n_cmp++;
    if (rd_key !== kb) begin n_err++; $display("FAIL held_rk0_b got %h exp %h", rd_key, kb); end
    compute_model(kb);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    n_cmp++;
    if (n !== 10) begin n_err++; $display("FAIL held_b_cycles got %0d exp 10", n); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1; n_cmp++;
      if (rd_key !== exp_rk[i]) begin n_err++; $display("FAIL held_rk_b[%0d] got %h exp %h", i, rd_key, exp_rk[i]); end
    end
  endtask

  task automatic test_random_keys();
    int n;
    logic [127:0] k;
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      compute_model(k);
      load_key(k);
      n = 0;
      while (busy && n < 40) begin n++; @(negedge clk); end
      n_cmp++;
      if (n !== 10 || keys_ready !== 1'b1) begin
        n_err++; $display("FAIL rand%0d_done got cycles=%0d ready=%b exp 10/1", t, n, keys_ready);
      end
      for (int i = 0; i < 16; i++) begin
        rd_idx = 4'(i); #1; n_cmp++;
        if (rd_key !== ((i <= 10) ? exp_rk[i] : 128'h0)) begin
          n_err++; $display("FAIL rand%0d_rk[%0d] got %h exp %h", t, i, rd_key, (i <= 10) ? exp_rk[i] : 128'h0);
        end
      end
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_ignored_load();
    test_reload();
    test_reset_midop();
    test_held_load();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
Iterative AES-128 key-schedule controller. It loads a 128-bit cipher key and reuses one shared expansion round datapath (RotWord, 4x SubBytes, Rcon XOR, XOR chain) once per cycle. It produces round keys 1..10 and stores all 11 keys in an internal register file. The cipher/decipher round sequencers read keys through an indexed read port, so the ten unrolled per-round generators are no longer needed.

Parameters:
NROUNDS, 10, number of expansion rounds; register file holds NROUNDS+1 keys; fixed at 10 for AES-128.
RCON_INIT, 8'h01, first round constant byte; placed in the MSB byte of the 32-bit rcon word.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
key_in  input  128  cipher key, bits [0:127]; word w0 = [0:31].
key_load  input  1  load request; sampled only while busy=0.
busy  output  1  expansion in progress.
keys_ready  output  1  all 11 round keys valid.
rd_idx  input  4  round key index 0..10.
rd_key  output  128  round key at rd_idx.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE; busy=0, keys_ready=0.
  - round counter=0; rcon byte=RCON_INIT.
  - All 11 register-file entries cleared to 0.
- States: IDLE, EXPAND.
- IDLE:
  - On key_load=1, at the clock edge: rk[0]<=key_in, work_key<=key_in, round<=1, rcon<=RCON_INIT.
  - Same edge: keys_ready<=0, busy<=1, go to EXPAND.
- EXPAND, each cycle:
  - nk = expand(work_key, {rcon,24'h0}), using the standard AES-128 step:
    - t = SubWord(RotWord(w3)) ^ rcon_word
    - y0 = w0^t; y1 = w1^y0; y2 = w2^y1; y3 = w3^y2.
  - At the edge: rk[round]<=nk, work_key<=nk, round<=round+1.
  - Rcon update: rcon<=xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Termination:
  - When round==NROUNDS, the edge writes rk[10] and goes to IDLE with busy<=0, keys_ready<=1.
- Latency: key_load accepted at edge E0; rk[k] is written at edge E0+k. busy is high for exactly 10 cycles. keys_ready is high from E10 onward.
- key_load while busy=1 is ignored (no restart, no queueing).
- key_load in IDLE when keys_ready=1 restarts: keys_ready drops on the accepting edge, and rk[0] is overwritten at once.
- key_load held high continuously:
  - One expansion, then a fresh load on the first IDLE cycle after completion.
  - keys_ready is high for that one IDLE cycle only.
- rd_key is combinational: rd_key = rk[rd_idx].
  - rd_idx 11..15 returns 128'h0.
  - Reads are allowed in any state. Entries with index >= round during EXPAND hold stale data; consumers must wait for keys_ready.
- Reset mid-expansion aborts immediately. Partial keys are discarded (cleared).
- SubBytes is one shared 4-byte sbox instance, combinational within the cycle. No multicycle path is allowed.

Test Plan:
- Reset then idle: rst pulse -> busy=0, keys_ready=0; rd_key=0 for rd_idx 0..15.
- FIPS-197 vector: key_in=2b7e151628aed2a6abf7158809cf4f3c, key_load 1 cycle -> busy high 10 cycles, then keys_ready=1. Expected keys:
  - rk[1]=a0fafe1788542cb123a339392a6c7605
  - rk[7]=4e54f70e5f5fc9f384a64fb24ea6dc4f
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6
  - rk[0]=key_in
- Ignored load: pulse key_load with key 000..0 on the 4th busy cycle -> final keys identical to the FIPS-197 result; busy still 10 cycles.
- Reload: after keys_ready, load key 000...0 -> keys_ready falls on the accepting edge; after 10 cycles rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset mid-op: assert rst on the 5th busy cycle -> busy=0, keys_ready=0, all entries 0. A following load completes normally.
- Out-of-range read: rd_idx=11 and rd_idx=15 -> rd_key=0. rd_idx=10 sampled at cycle offset 9 and at offset 10 after load -> old value at offset 9, new rk[10] at offset 10.
